// File: rtl/neuron_mac_if.sv
// Operand-buffer <-> neuron handshake bundle: operand/weight fetch, launch and result.
interface neuron_mac_if;
    logic               ready;
    logic signed [15:0] x;
    logic signed [15:0] w;
    logic signed [15:0] bias;
    logic        [1:0]  sel;
    logic               neuron_done;
    logic signed [15:0] y;
    logic               busy;

    modport master (
        output ready, x, w, bias,
        input  sel, neuron_done, y, busy
    );

    modport slave (
        input  ready, x, w, bias,
        output sel, neuron_done, y, busy
    );
endinterface

// File: rtl/neuron_mac.sv
// Single-neuron Q8.8 multiply-accumulate: bias + sum of three x*w, saturated to 16 bits.
// Optional ReLU on the result is enabled by defining NEURON_RELU_EN.
module neuron_mac #(
    parameter int FRAC_BITS = 8,
    parameter int ACC_W     = 34
) (
    input  logic         clk,
    input  logic         reset,
    neuron_mac_if.slave  bus
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_MAC1 = 3'd1;
    localparam logic [2:0] ST_MAC2 = 3'd2;
    localparam logic [2:0] ST_MAC3 = 3'd3;
    localparam logic [2:0] ST_OUT  = 3'd4;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

    logic [2:0]               state_q, state_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [15:0]       y_q, y_d;
    logic [1:0]               sel_q, sel_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic signed [31:0]       prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [15:0]       sat;
    logic signed [15:0]       y_res;

    always_comb begin
        prod     = 32'(bus.x) * 32'(bus.w);
        prod_ext = {{(ACC_W-32){prod[31]}}, prod};
        bias_ext = {{(ACC_W-16){bus.bias[15]}}, bus.bias};
        sum      = acc_q + prod_ext;
        shifted  = sum >>> FRAC_BITS;

        if (shifted > SAT_MAX) begin
            sat = 16'sh7FFF;
        end else if (shifted < SAT_MIN) begin
            sat = 16'sh8000;
        end else begin
            sat = shifted[15:0];
        end

`ifdef NEURON_RELU_EN
        y_res = sat[15] ? 16'sh0000 : sat;
`else
        y_res = sat;
`endif
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        y_d     = y_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.ready) begin
                    state_d = ST_MAC1;
                    acc_d   = bias_ext <<< FRAC_BITS;
                end
            end
            ST_MAC1: begin
                acc_d   = sum;
                state_d = ST_MAC2;
            end
            ST_MAC2: begin
                acc_d   = sum;
                state_d = ST_MAC3;
            end
            ST_MAC3: begin
                acc_d   = sum;
                y_d     = y_res;
                state_d = ST_OUT;
            end
            ST_OUT:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered, so decode them from the state being entered.
        case (state_d)
            ST_MAC1: sel_d = 2'd1;
            ST_MAC2: sel_d = 2'd2;
            ST_MAC3: sel_d = 2'd3;
            default: sel_d = 2'd0;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_OUT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            y_q     <= '0;
            sel_q   <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.sel         = sel_q;
    assign bus.busy        = busy_q;
    assign bus.neuron_done = done_q;
    assign bus.y           = y_q;

endmodule
